// File: rtl/mips_bus_if.sv
// Instruction fetch and data-memory bus between the single-cycle core and its memories.
interface mips_bus_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 16;

    logic [XLEN-1:0] INSTRUCTION;
    logic [XLEN-1:0] DM_Q;
    logic            DM_WE;
    logic [XLEN-1:0] DM_D;
    logic [AW-1:0]   DM_ADDR;
    logic [XLEN-1:0] NEXT_PC;

    modport master (input INSTRUCTION, DM_Q, output DM_WE, DM_D, DM_ADDR, NEXT_PC);
    modport slave  (output INSTRUCTION, DM_Q, input DM_WE, DM_D, DM_ADDR, NEXT_PC);
endinterface

// File: rtl/mips_single_cycle_core.sv
// Single-cycle MIPS-like core: combinational decode/execute/memory, register file and PC update at posedge.
// Optional R-type AND/OR/SLT enabled by defining MIPS_RTYPE_LOGIC_EN.
module mips_single_cycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      rst,
    mips_bus_if.master bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned RIW  = 5;
    localparam int unsigned AW   = 16;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JMP   = 6'b010000;
    localparam logic [5:0] OP_ADDI  = 6'b100000;
    localparam logic [5:0] OP_SUBI  = 6'b100001;
    localparam logic [5:0] OP_LWR   = 6'b100111;
    localparam logic [5:0] OP_SWR   = 6'b101000;
    localparam logic [5:0] OP_LWI   = 6'b101001;
    localparam logic [5:0] OP_SWI   = 6'b101010;
    localparam logic [5:0] OP_BNE   = 6'b101100;

    localparam logic [5:0] FN_ADD = 6'b000000;
    localparam logic [5:0] FN_SUB = 6'b000001;
`ifdef MIPS_RTYPE_LOGIC_EN
    localparam logic [5:0] FN_AND = 6'b000010;
    localparam logic [5:0] FN_OR  = 6'b000011;
    localparam logic [5:0] FN_SLT = 6'b000100;
`endif

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] regs_q [NREG];

    logic [5:0]      opcode, func;
    logic [RIW-1:0]  rs_idx, rt_idx, rd_idx;
    logic [15:0]     imm;
    logic [25:0]     target;
    logic [XLEN-1:0] rs_val, rt_val, simm, eaddr, pc_plus4;

    logic            wr_en_c;
    logic [RIW-1:0]  wr_idx_c;
    logic [XLEN-1:0] wr_data_c;
    logic            dm_we_c;
    logic [AW-1:0]   dm_addr_c;
    logic [XLEN-1:0] dm_d_c;
    logic            unused_c;

    assign opcode = bus.INSTRUCTION[31:26];
    assign rs_idx = bus.INSTRUCTION[25:21];
    assign rt_idx = bus.INSTRUCTION[20:16];
    assign rd_idx = bus.INSTRUCTION[15:11];
    assign func   = bus.INSTRUCTION[5:0];
    assign imm    = bus.INSTRUCTION[15:0];
    assign target = bus.INSTRUCTION[25:0];

    // R0 is hardwired to zero regardless of array contents
    assign rs_val   = (rs_idx == '0) ? '0 : regs_q[rs_idx];
    assign rt_val   = (rt_idx == '0) ? '0 : regs_q[rt_idx];
    assign simm     = {{(XLEN-16){imm[15]}}, imm};
    assign eaddr    = rs_val + simm;
    assign pc_plus4 = pc_q + XLEN'(4);
    assign unused_c = ^{bus.INSTRUCTION[10:6], eaddr[XLEN-1:AW]};

    always_comb begin
        wr_en_c   = 1'b0;
        wr_idx_c  = '0;
        wr_data_c = '0;
        dm_we_c   = 1'b0;
        dm_addr_c = '0;
        dm_d_c    = '0;
        pc_d      = pc_plus4;
        case (opcode)
            OP_RTYPE: begin
                wr_idx_c = rd_idx;
                case (func)
                    FN_ADD: begin wr_en_c = 1'b1; wr_data_c = rs_val + rt_val; end
                    FN_SUB: begin wr_en_c = 1'b1; wr_data_c = rs_val - rt_val; end
`ifdef MIPS_RTYPE_LOGIC_EN
                    FN_AND: begin wr_en_c = 1'b1; wr_data_c = rs_val & rt_val; end
                    FN_OR:  begin wr_en_c = 1'b1; wr_data_c = rs_val | rt_val; end
                    FN_SLT: begin
                        wr_en_c   = 1'b1;
                        wr_data_c = XLEN'($signed(rs_val) < $signed(rt_val));
                    end
`endif
                    default: wr_en_c = 1'b0;
                endcase
            end
            OP_ADDI: begin wr_en_c = 1'b1; wr_idx_c = rt_idx; wr_data_c = rs_val + simm; end
            OP_SUBI: begin wr_en_c = 1'b1; wr_idx_c = rt_idx; wr_data_c = rs_val - simm; end
            OP_LWR: begin
                wr_en_c   = 1'b1;
                wr_idx_c  = rt_idx;
                dm_addr_c = eaddr[AW-1:0];
                wr_data_c = bus.DM_Q;
            end
            OP_LWI: begin
                wr_en_c   = 1'b1;
                wr_idx_c  = rt_idx;
                dm_addr_c = imm;
                wr_data_c = bus.DM_Q;
            end
            OP_SWR: begin dm_we_c = 1'b1; dm_addr_c = eaddr[AW-1:0]; dm_d_c = rt_val; end
            OP_SWI: begin dm_we_c = 1'b1; dm_addr_c = imm;           dm_d_c = rt_val; end
            OP_BNE: begin
                if (rs_val != rt_val) pc_d = pc_plus4 + (simm << 2);
            end
            OP_JMP:  pc_d = {pc_q[XLEN-1:28], target, 2'b00};
            default: pc_d = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               regs_q <= '{default: '0};
        else if (wr_en_c && (wr_idx_c != '0))  regs_q[wr_idx_c] <= wr_data_c;
    end

    // Store enable is masked while in reset so no memory write leaks through
    assign bus.DM_WE   = dm_we_c & ~rst;
    assign bus.DM_ADDR = dm_addr_c;
    assign bus.DM_D    = dm_d_c;
    assign bus.NEXT_PC = pc_q;
endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Self-checking bench for mips_single_cycle_core: directed program checks plus randomized
// instructions compared against an instruction-level reference model.
module tb_mips_single_cycle_core;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [5:0] ADDI = 6'h20, SUBI = 6'h21, LWR = 6'h27, SWR = 6'h28;
    localparam logic [5:0] LWI = 6'h29, SWI = 6'h2A, BNE = 6'h2C, JMP = 6'h10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] instr_drv = 32'hFC00_0000;

    mips_bus_if bus();
    mips_single_cycle_core #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Environment data memory, written only by the DUT
    logic [31:0] mem [65536] = '{default: '0};
    assign bus.INSTRUCTION = instr_drv;
    assign bus.DM_Q        = mem[bus.DM_ADDR];
    always @(posedge clk) if (bus.DM_WE) mem[bus.DM_ADDR] <= bus.DM_D;

    // Reference model state
    logic [31:0] ref_regs [32];
    logic [31:0] ref_mem  [65536] = '{default: '0};
    logic [31:0] ref_pc;
    logic        e_we, e_wr;
    logic [15:0] e_addr;
    logic [31:0] e_d, e_npc, e_val;
    logic [4:0]  e_rd;
    logic [31:0] imem [256];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {JMP, t};
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        ref_pc = RST_PC;
    endtask

    // Instruction semantics straight from the ISA description
    task automatic ref_eval(input logic [31:0] ins);
        logic [31:0] rs, rt, simm;
        int s;
        rs   = ref_regs[ins[25:21]];
        rt   = ref_regs[ins[20:16]];
        s    = $signed(ins[15:0]);
        simm = s;
        e_we = 0; e_addr = 0; e_d = 0; e_npc = ref_pc + 4; e_wr = 0; e_rd = ins[20:16]; e_val = 0;
        case (ins[31:26])
            6'h00: begin
                e_rd = ins[15:11];
                e_wr = 1;
                case (ins[5:0])
                    6'd0: e_val = rs + rt;
                    6'd1: e_val = rs - rt;
`ifdef MIPS_RTYPE_LOGIC_EN
                    6'd2: e_val = rs & rt;
                    6'd3: e_val = rs | rt;
                    6'd4: e_val = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
`endif
                    default: e_wr = 0;
                endcase
            end
            ADDI: begin e_wr = 1; e_val = rs + simm; end
            SUBI: begin e_wr = 1; e_val = rs - simm; end
            LWR:  begin e_wr = 1; e_addr = 16'(rs + simm); e_val = ref_mem[e_addr]; end
            LWI:  begin e_wr = 1; e_addr = ins[15:0];      e_val = ref_mem[e_addr]; end
            SWR:  begin e_we = 1; e_addr = 16'(rs + simm); e_d = rt; end
            SWI:  begin e_we = 1; e_addr = ins[15:0];      e_d = rt; end
            BNE:  if (rs != rt) e_npc = ref_pc + 4 + simm * 4;
            JMP:  e_npc = {ref_pc[31:28], ins[25:0], 2'b00};
            default: e_wr = 0;
        endcase
    endtask

    task automatic ref_commit();
        ref_pc = e_npc;
        if (e_wr && e_rd != 0) ref_regs[e_rd] = e_val;
        if (e_we) ref_mem[e_addr] = e_d;
    endtask

    // Called at a negedge: drive, compare this cycle's outputs against the model
    task automatic issue(input logic [31:0] ins);
        instr_drv = ins;
        #1;
        ref_eval(ins);
        check("next_pc", bus.NEXT_PC, ref_pc);
        check("dm_we",   32'(bus.DM_WE), 32'(e_we));
        check("dm_addr", 32'(bus.DM_ADDR), 32'(e_addr));
        check("dm_d",    bus.DM_D, e_d);
    endtask

    task automatic retire();
        ref_commit();
        @(negedge clk);
    endtask

    task automatic exec(input logic [31:0] ins);
        issue(ins);
        retire();
    endtask

    // Called at a negedge: hold reset across one posedge with ins on the bus
    task automatic do_reset(input logic [31:0] ins);
        instr_drv = ins;
        rst = 1'b1;
        #1;
        check("rst_pc", bus.NEXT_PC, RST_PC);
        check("rst_we", 32'(bus.DM_WE), 32'd0);
        @(negedge clk);
        check("rst_hold_pc", bus.NEXT_PC, RST_PC);
        check("rst_hold_we", 32'(bus.DM_WE), 32'd0);
        ref_reset();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] last_a, last_d, ins;
        logic [5:0]  ops [12];
        ops = '{6'h00, 6'h00, ADDI, SUBI, LWR, LWI, SWR, SWI, BNE, JMP, 6'h3F, 6'h05};
        for (int i = 0; i < 256; i++) imem[i] = 32'hFC00_0000;
        imem[16] = enc_i(ADDI, 0, 1, 16'd7);
        imem[17] = enc_i(SWI,  0, 1, 16'd0);
        imem[18] = enc_i(ADDI, 0, 1, 16'd3);
        imem[19] = enc_i(SWI,  0, 1, 16'd1);
        imem[20] = enc_i(LWI,  0, 1, 16'd0);
        imem[21] = enc_i(LWI,  0, 2, 16'd1);
        imem[22] = enc_i(ADDI, 0, 3, 16'd0);
        imem[23] = enc_r(6'd0, 3, 1, 3);
        imem[24] = enc_i(SUBI, 2, 2, 16'd1);
        imem[25] = enc_i(BNE,  2, 0, 16'hFFFD);
        imem[26] = enc_i(SWI,  0, 3, 16'd2);
        imem[27] = enc_j(26'd27);

        ref_reset();
        do_reset(enc_i(SWI, 0, 0, 16'd5));

        // Immediate add then absolute store
        exec(enc_i(ADDI, 0, 4, 16'd7));
        issue(enc_i(SWI, 0, 4, 16'd5));
        check("swi_we", 32'(bus.DM_WE), 32'd1);
        check("swi_addr", 32'(bus.DM_ADDR), 32'd5);
        check("swi_d", bus.DM_D, 32'd7);
        retire();

        // Load then register-relative store; writes to R0 are dropped
        exec(enc_i(ADDI, 0, 5, 16'h1234));
        exec(enc_i(SWI, 0, 5, 16'd1));
        issue(enc_i(LWI, 0, 2, 16'd1));
        check("lwi_addr", 32'(bus.DM_ADDR), 32'd1);
        check("lwi_q", bus.DM_Q, 32'h1234);
        retire();
        issue(enc_i(SWR, 0, 2, 16'd3));
        check("swr_addr", 32'(bus.DM_ADDR), 32'd3);
        check("swr_d", bus.DM_D, 32'h1234);
        retire();
        exec(enc_i(ADDI, 0, 0, 16'd5));
        exec(enc_i(LWI, 0, 0, 16'd1));
        issue(enc_i(SWI, 0, 0, 16'd4));
        check("r0_zero", bus.DM_D, 32'd0);
        retire();

        // Branch taken / not taken and jump targets
        exec(enc_i(ADDI, 0, 1, 16'd1));
        exec(enc_j(26'd8));
        check("jmp_to_20", bus.NEXT_PC, 32'h20);
        exec(enc_i(BNE, 1, 0, 16'hFFFE));
        check("bne_taken", bus.NEXT_PC, 32'h1C);
        exec(enc_j(26'd8));
        exec(enc_i(BNE, 0, 0, 16'hFFFE));
        check("bne_not_taken", bus.NEXT_PC, 32'h24);
        exec(enc_j(26'd12));
        check("jmp_to_30", bus.NEXT_PC, 32'h30);
        exec(enc_j(26'd7));
        check("jmp_t7", bus.NEXT_PC, 32'h1C);

        // Mid-run reset with a store on the bus
        do_reset(enc_i(SWI, 0, 4, 16'd9));
        check("rst_no_store", mem[9], ref_mem[9]);
        issue(enc_i(SWR, 0, 4, 16'd9));
        check("rst_reg_clear", bus.DM_D, 32'd0);
        retire();
        issue(enc_i(SWR, 0, 5, 16'd10));
        check("rst_reg_clear2", bus.DM_D, 32'd0);
        retire();

        // Multiply loop at 0x40: 7 * 3 stored to mem[2]
        exec(enc_j(26'd16));
        last_a = '1;
        last_d = '1;
        for (int k = 0; k < 40; k++) begin
            issue(imem[ref_pc[9:2]]);
            if (bus.DM_WE) begin
                last_a = 32'(bus.DM_ADDR);
                last_d = bus.DM_D;
            end
            retire();
        end
        check("mul_addr", last_a, 32'd2);
        check("mul_result", last_d, 32'd21);

        // Randomized instruction stream with one reset in the middle
        for (int n = 0; n < 400; n++) begin
            logic [5:0]  op;
            logic [15:0] imm;
            op  = ops[$urandom_range(0, 11)];
            imm = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            if (op == 6'h00)
                ins = enc_r(6'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            else if (op == JMP)
                ins = enc_j(26'($urandom));
            else
                ins = enc_i(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), imm);
            if (n == 200) do_reset(enc_i(SWR, 5'($urandom_range(1, 7)), 5'($urandom_range(1, 7)), imm));
            exec(ins);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
